// File: rtl/dbus_sram_responder.sv
// Single-port word RAM answering dbus requests with a fixed response latency.
// Optional macro DBUS_RESP_RANDOM_STALL_EN adds LFSR-driven stalls in WAIT.
module dbus_sram_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_dreq_valid,
    input  logic [31:0] i_dreq_addr,
    input  logic [2:0]  i_dreq_size,
    input  logic [3:0]  i_dreq_strobe,
    input  logic [31:0] i_dreq_data,
    output logic        o_dresp_addr_ok,
    output logic        o_dresp_data_ok,
    output logic [31:0] o_dresp_data
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [AW-1:0] r_idx;
    logic [3:0]    r_strb;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH];

    logic [AW-1:0] w_req_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_accept;
    logic          w_release;
    logic          w_unused_bits;

    assign w_req_idx     = i_dreq_addr[AW+1:2];
    assign w_accept      = i_dreq_valid && (r_state == S_IDLE) && !reset;
    assign w_rd_idx      = (r_state == S_IDLE) ? w_req_idx : r_idx;
    assign w_unused_bits = ^{i_dreq_size, i_dreq_addr[31:AW+2], i_dreq_addr[1:0]};
    assign o_dresp_data  = r_rdata;

`ifdef DBUS_RESP_RANDOM_STALL_EN
    localparam bit DIRECT_RESP = 1'b0;
    logic [7:0] r_lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_lfsr <= 8'hA5;
        else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    assign w_release = (r_cnt <= 4'd1) && !r_lfsr[0];
`else
    localparam bit DIRECT_RESP = (LATENCY == 1);

    // WAIT exits on the edge where the counter reaches 0, giving exactly LATENCY cycles.
    assign w_release = (r_cnt <= 4'd1);
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        o_dresp_addr_ok = 1'b0;
        o_dresp_data_ok = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_dresp_addr_ok = w_accept;
                if (w_accept) begin
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = DIRECT_RESP ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
                if (w_release) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                o_dresp_data_ok = 1'b1;
                w_state_nxt     = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_strb  <= 4'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx   <= w_req_idx;
                r_strb  <= i_dreq_strobe;
                r_wdata <= i_dreq_data;
            end
            // Read on entry to RESP so the returned word precedes this request's write.
            r_rdata <= (w_state_nxt == S_RESP) ? r_mem[w_rd_idx] : 32'd0;
        end
    end

    // NOTE: the RAM array has no reset; clearing it would forbid block-RAM mapping.
    always_ff @(posedge clk) begin
        if (r_state == S_RESP) begin
            for (int i = 0; i < 4; i++) begin
                if (r_strb[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

endmodule
